// File: rtl/led_ctrl_if.sv
// led_ctrl_if: femtorv32 memory bus slice for the LED region.
// The master drives the request and the slave answers with read data.
interface led_ctrl_if;
    logic        sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    modport master (
        output sel,
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        output mem_rstrb,
        input  mem_rdata,
        input  mem_rbusy,
        input  mem_wbusy
    );

    modport slave (
        input  sel,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        input  mem_rstrb,
        output mem_rdata,
        output mem_rbusy,
        output mem_wbusy
    );
endinterface

// File: rtl/led_ctrl.sv
// led_ctrl: LED data register plus per-LED blink engine.
// Registers: DATA, BLINK, PERIOD and a read-only STATUS word.
module led_ctrl #(
    parameter int NUM_LEDS = 8,
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                resetn,
    led_ctrl_if.slave           bus,
    output logic [NUM_LEDS-1:0] leds
);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_BLINK  = 2'd1;
    localparam logic [1:0] OFF_PERIOD = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic [NUM_LEDS-1:0] data_q;
    logic [NUM_LEDS-1:0] blink_q;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic                phase_q;
    logic [15:0]         tcount_q;
    logic [31:0]         rdata_q;
    logic [31:0]         rd_val;

    logic [1:0] off;
    logic       wr;
    logic       rd;
    logic       period_wr;
    logic       unused_bits;

    assign off       = bus.mem_addr[3:2];
    assign wr        = bus.sel && (bus.mem_wmask != 4'd0);
    assign rd        = bus.sel && bus.mem_rstrb;
    assign period_wr = wr && (off == OFF_PERIOD);

    assign unused_bits = ^{bus.mem_addr[31:4], bus.mem_addr[1:0]};

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_rbusy = 1'b0;
    assign bus.mem_wbusy = 1'b0;

    // Byte-lane merge of write data over the current register value.
    function automatic logic [31:0] merge(
        input logic [31:0] cur,
        input logic [31:0] wd,
        input logic [3:0]  m
    );
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Read mux: select the addressed register, zero-extended.
    always_comb begin
        rd_val = '0;
        unique case (off)
            OFF_DATA:   rd_val = 32'(data_q);
            OFF_BLINK:  rd_val = 32'(blink_q);
            OFF_PERIOD: rd_val = 32'(period_q);
            OFF_STATUS: rd_val = {tcount_q, 15'd0, phase_q};
        endcase
    end

    // Register file writes; STATUS is read-only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q   <= '0;
            blink_q  <= '0;
            period_q <= '0;
        end else if (wr) begin
            if (off == OFF_DATA)
                data_q <= NUM_LEDS'(merge(32'(data_q), bus.mem_wdata,
                                          bus.mem_wmask));
            if (off == OFF_BLINK)
                blink_q <= NUM_LEDS'(merge(32'(blink_q), bus.mem_wdata,
                                           bus.mem_wmask));
            if (off == OFF_PERIOD)
                period_q <= PERIOD_W'(merge(32'(period_q), bus.mem_wdata,
                                            bus.mem_wmask));
        end
    end

    // Blink engine; a PERIOD write restarts the half-period from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            tcount_q <= '0;
        end else if (period_wr || period_q == '0) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == period_q) begin
            cnt_q    <= '0;
            phase_q  <= ~phase_q;
            tcount_q <= tcount_q + 16'd1;
        end else begin
            cnt_q <= cnt_q + PERIOD_W'(1);
        end
    end

    // Read data is a one-cycle pulse after a selected strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rdata_q <= '0;
        else if (rd)  rdata_q <= rd_val;
        else          rdata_q <= '0;
    end

    // Registered LED drive.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) leds <= '0;
        else         leds <= data_q ^ (blink_q & {NUM_LEDS{phase_q}});
    end

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed vectors and blink sequences for led_ctrl.
// Drives the bus #1 after each rising edge and samples there.
module tb_led_ctrl;

    logic       clk;
    logic       resetn;
    logic [7:0] leds;

    led_ctrl_if bus ();

    led_ctrl #(
        .NUM_LEDS(8),
        .PERIOD_W(24)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus),
        .leds  (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        sel;
        logic [3:0]  wmask;
        logic [1:0]  woff;
        logic [31:0] wdata;
        logic [1:0]  roff;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.sel       = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        bus.mem_rstrb = 1'b0;
    endtask

    task automatic wr(input logic s, input logic [1:0] o,
                      input logic [31:0] d, input logic [3:0] m);
        bus.sel       = s;
        bus.mem_addr  = {28'd0, o, 2'b00};
        bus.mem_wdata = d;
        bus.mem_wmask = m;
        bus.mem_rstrb = 1'b0;
        tick();
        idle();
    endtask

    task automatic rd(input logic s, input logic [1:0] o,
                      output logic [31:0] v);
        bus.sel       = s;
        bus.mem_addr  = {28'd0, o, 2'b00};
        bus.mem_wmask = '0;
        bus.mem_rstrb = 1'b1;
        tick();
        v = bus.mem_rdata;
        idle();
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  exp_l;

        vecs[0]  = '{1'b1, 4'hF, 2'd0, 32'h000000A5, 2'd0, 32'h000000A5, 8'hA5};
        vecs[1]  = '{1'b1, 4'h1, 2'd0, 32'h12345678, 2'd0, 32'h00000078, 8'h78};
        vecs[2]  = '{1'b0, 4'hF, 2'd0, 32'h000000FF, 2'd0, 32'h00000078, 8'h78};
        vecs[3]  = '{1'b1, 4'h2, 2'd0, 32'h0000FF00, 2'd0, 32'h00000078, 8'h78};
        vecs[4]  = '{1'b1, 4'hF, 2'd1, 32'hFFFFFF3C, 2'd1, 32'h0000003C, 8'h78};
        vecs[5]  = '{1'b1, 4'h8, 2'd2, 32'hFFFFFFFF, 2'd2, 32'h00000000, 8'h78};
        vecs[6]  = '{1'b1, 4'h6, 2'd2, 32'h00123456, 2'd2, 32'h00123400, 8'h78};
        vecs[7]  = '{1'b1, 4'hF, 2'd3, 32'hFFFFFFFF, 2'd3, 32'h00000000, 8'h78};
        vecs[8]  = '{1'b1, 4'hF, 2'd2, 32'h00000000, 2'd2, 32'h00000000, 8'h78};
        vecs[9]  = '{1'b1, 4'hF, 2'd1, 32'h00000000, 2'd1, 32'h00000000, 8'h78};
        vecs[10] = '{1'b1, 4'hF, 2'd0, 32'h00000000, 2'd0, 32'h00000000, 8'h00};

        resetn = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_leds", {24'd0, leds}, 32'd0);
        check("reset_rdata", bus.mem_rdata, 32'd0);
        check("rbusy", {31'd0, bus.mem_rbusy}, 32'd0);
        check("wbusy", {31'd0, bus.mem_wbusy}, 32'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            rd(1'b1, 2'(i), v);
            check($sformatf("reset_read_%0d", i), v, 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wmask != 4'd0)
                wr(vecs[i].sel, vecs[i].woff, vecs[i].wdata, vecs[i].wmask);
            rd(1'b1, vecs[i].roff, v);
            check($sformatf("vec%0d_rd", i), v, vecs[i].exp_rd);
            check($sformatf("vec%0d_leds", i), {24'd0, leds},
                  {24'd0, vecs[i].exp_leds});
        end

        wr(1'b1, 2'd1, 32'h0000000F, 4'hF);
        rd(1'b1, 2'd1, v);
        check("blink_rd_pulse", v, 32'h0000000F);
        tick();
        check("blink_rd_clear", bus.mem_rdata, 32'd0);
        rd(1'b0, 2'd1, v);
        check("unsel_rd", v, 32'd0);

        bus.sel       = 1'b1;
        bus.mem_addr  = 32'h4;
        bus.mem_wdata = 32'h000000F0;
        bus.mem_wmask = 4'hF;
        bus.mem_rstrb = 1'b1;
        tick();
        idle();
        check("rw_same_old", bus.mem_rdata, 32'h0000000F);
        rd(1'b1, 2'd1, v);
        check("rw_same_new", v, 32'h000000F0);
        wr(1'b1, 2'd1, 32'h0000000F, 4'hF);

        wr(1'b1, 2'd2, 32'd3, 4'hF);
        for (int k = 1; k <= 40; k++) begin
            tick();
            exp_l = (((k - 1) / 4) % 2 == 1) ? 8'h0F : 8'h00;
            check($sformatf("blink_k%0d", k), {24'd0, leds}, {24'd0, exp_l});
        end
        rd(1'b1, 2'd3, v);
        check("status_10", v, 32'h000A0000);

        repeat (6) tick();
        wr(1'b1, 2'd2, 32'd3, 4'hF);
        check("restart_leds_old", {24'd0, leds}, 32'h0F);
        rd(1'b1, 2'd3, v);
        check("restart_status", v, 32'h000B0000);
        check("restart_leds_w1", {24'd0, leds}, 32'h00);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("restart_w%0d", k), {24'd0, leds}, 32'h00);
        end
        tick();
        check("restart_w5", {24'd0, leds}, 32'h0F);

        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_leds", {24'd0, leds}, 32'd0);
        check("async_rst_rdata", bus.mem_rdata, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        rd(1'b1, 2'd2, v);
        check("post_rst_period", v, 32'd0);
        rd(1'b1, 2'd3, v);
        check("post_rst_status", v, 32'd0);
        rd(1'b1, 2'd1, v);
        check("post_rst_blink", v, 32'd0);
        check("post_rst_leds", {24'd0, leds}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
